// File: rtl/pcid_tlb.sv
// pcid_tlb: set-associative, PCID-tagged TLB with a valid/ready lookup port,
// fill-in-place updates, tree-PLRU replacement, three invalidation modes
// (page, per-PCID sweep, global flush) and saturating hit/miss statistics.
module pcid_tlb #(
  parameter int SADDR = 64,
  parameter int SPAGE = 12,
  parameter int NSET  = 8,
  parameter int NWAY  = 8,
  parameter int SPCID = 12
) (
  input  logic             clk,
  input  logic             shutdown_n,
  input  logic             lookup_valid,
  output logic             lookup_ready,
  input  logic [SADDR-1:0] lookup_va,
  input  logic [SPCID-1:0] lookup_pcid,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [SADDR-1:0] resp_pa,
  input  logic             fill_valid,
  input  logic [SADDR-1:0] fill_va,
  input  logic [SPCID-1:0] fill_pcid,
  input  logic [SADDR-1:0] fill_pa,
  input  logic             inv_valid,
  input  logic [1:0]       inv_mode,
  input  logic [SADDR-1:0] inv_va,
  input  logic [SPCID-1:0] inv_pcid,
  output logic             inv_busy,
  output logic [63:0]      stat_hit,
  output logic [63:0]      stat_miss
);

  localparam int SIDX = $clog2(NSET);
  localparam int SWAY = $clog2(NWAY);
  localparam int STAG = SADDR - SPAGE - SIDX;
  localparam int SPPN = SADDR - SPAGE;

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t           state;
  logic [SIDX-1:0]  sweep_idx;
  logic [SPCID-1:0] sweep_pcid;

  logic [NWAY-1:0]  valid_q [NSET];
  logic [NWAY-2:0]  plru_q  [NSET];
  logic [SPCID-1:0] pcid_q  [NSET][NWAY];
  logic [STAG-1:0]  tag_q   [NSET][NWAY];
  logic [SPPN-1:0]  ppn_q   [NSET][NWAY];

  logic            accept_lk, fill_en;
  logic [SIDX-1:0] lk_set, fl_set, iv_set;
  logic            lk_hit, fl_hit, fl_free;
  logic [SWAY-1:0] lk_way, fl_hit_way, fl_free_way, fl_way;
  logic [SPPN-1:0] lk_ppn;
  logic [NWAY-1:0] iv_clear, sw_clear;
  logic [NWAY-2:0] plru_lk_new, plru_fill_base, plru_fl_new;
  logic            unused_bits;

  // Tree-PLRU victim: walk from the root, each node bit selecting the subtree
  // to evict from (0 = lower-index half, 1 = upper-index half).
  function automatic logic [SWAY-1:0] plru_victim(input logic [NWAY-2:0] bits);
    int node;
    node = 1;
    for (int l = 0; l < SWAY; l++) node = 2 * node + int'(bits[node-1]);
    return SWAY'(node - NWAY);
  endfunction

  // Tree-PLRU touch: every node on the path to the way points to the other half.
  function automatic logic [NWAY-2:0] plru_touch(input logic [NWAY-2:0] bits,
                                                 input logic [SWAY-1:0] way);
    logic [NWAY-2:0] r;
    logic            dir;
    int              node;
    r    = bits;
    node = 1;
    for (int l = 0; l < SWAY; l++) begin
      dir       = way[SWAY-1-l];
      r[node-1] = ~dir;
      node      = 2 * node + int'(dir);
    end
    return r;
  endfunction

  assign lookup_ready = (state == IDLE);
  assign inv_busy     = (state == SWEEP);
  assign accept_lk    = lookup_valid && (state == IDLE);
  assign fill_en      = fill_valid && (state == IDLE) && !inv_valid;
  assign lk_set       = lookup_va[SPAGE +: SIDX];
  assign fl_set       = fill_va[SPAGE +: SIDX];
  assign iv_set       = inv_va[SPAGE +: SIDX];
  assign unused_bits  = ^{fill_pa[SPAGE-1:0], inv_va[SPAGE-1:0]};

  // Tag/PCID match for lookup, fill and page invalidation, plus fill way choice
  // and the PLRU updates (a fill touch is applied on top of a same-set hit touch).
  always_comb begin
    lk_hit      = 1'b0;
    lk_way      = '0;
    lk_ppn      = '0;
    fl_hit      = 1'b0;
    fl_hit_way  = '0;
    fl_free     = 1'b0;
    fl_free_way = '0;
    iv_clear    = '0;
    sw_clear    = '0;
    for (int w = 0; w < NWAY; w++) begin
      if (valid_q[lk_set][w] && tag_q[lk_set][w] == lookup_va[SADDR-1 -: STAG] &&
          pcid_q[lk_set][w] == lookup_pcid) begin
        lk_hit = 1'b1;
        lk_way = SWAY'(w);
        lk_ppn = ppn_q[lk_set][w];
      end
      if (valid_q[fl_set][w] && tag_q[fl_set][w] == fill_va[SADDR-1 -: STAG] &&
          pcid_q[fl_set][w] == fill_pcid) begin
        fl_hit     = 1'b1;
        fl_hit_way = SWAY'(w);
      end
      iv_clear[w] = valid_q[iv_set][w] && tag_q[iv_set][w] == inv_va[SADDR-1 -: STAG] &&
                    pcid_q[iv_set][w] == inv_pcid;
      sw_clear[w] = (pcid_q[sweep_idx][w] == sweep_pcid);
    end
    for (int w = NWAY - 1; w >= 0; w--) begin
      if (!valid_q[fl_set][w]) begin
        fl_free     = 1'b1;
        fl_free_way = SWAY'(w);
      end
    end
    fl_way = fl_hit ? fl_hit_way : (fl_free ? fl_free_way : plru_victim(plru_q[fl_set]));
    plru_lk_new    = plru_touch(plru_q[lk_set], lk_way);
    plru_fill_base = (accept_lk && lk_hit && lk_set == fl_set) ? plru_lk_new : plru_q[fl_set];
    plru_fl_new    = plru_touch(plru_fill_base, fl_way);
  end

  // Control state: responses, statistics, valid/PLRU bits and the sweep FSM.
  always_ff @(posedge clk) begin
    if (!shutdown_n) begin
      state      <= IDLE;
      sweep_idx  <= '0;
      sweep_pcid <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_pa    <= '0;
      stat_hit   <= '0;
      stat_miss  <= '0;
      for (int s = 0; s < NSET; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      resp_valid <= accept_lk;
      resp_hit   <= accept_lk && lk_hit;
      resp_pa    <= (accept_lk && lk_hit) ? {lk_ppn, lookup_va[SPAGE-1:0]} : '0;
      if (accept_lk) begin
        if (lk_hit) begin
          if (stat_hit != '1) stat_hit <= stat_hit + 64'd1;
          plru_q[lk_set] <= plru_lk_new;
        end else if (stat_miss != '1) begin
          stat_miss <= stat_miss + 64'd1;
        end
      end
      if (fill_en) begin
        valid_q[fl_set][fl_way] <= 1'b1;
        plru_q[fl_set]          <= plru_fl_new;
      end
      case (state)
        IDLE: begin
          if (inv_valid) begin
            case (inv_mode)
              2'd0: valid_q[iv_set] <= valid_q[iv_set] & ~iv_clear;
              2'd1: begin
                state      <= SWEEP;
                sweep_idx  <= '0;
                sweep_pcid <= inv_pcid;
              end
              2'd2: begin
                for (int s = 0; s < NSET; s++) begin
                  valid_q[s] <= '0;
                  plru_q[s]  <= '0;
                end
              end
              default: ;
            endcase
          end
        end
        SWEEP: begin
          valid_q[sweep_idx] <= valid_q[sweep_idx] & ~sw_clear;
          sweep_idx          <= sweep_idx + 1'b1;
          if (sweep_idx == SIDX'(NSET - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Entry payload storage; only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      pcid_q[fl_set][fl_way] <= fill_pcid;
      tag_q[fl_set][fl_way]  <= fill_va[SADDR-1 -: STAG];
      ppn_q[fl_set][fl_way]  <= fill_pa[SADDR-1:SPAGE];
    end
  end

endmodule

// File: tb/tb_pcid_tlb.sv
// tb_pcid_tlb: randomized and directed stimulus against a behavioural TLB
// model; expected responses go through a scoreboard queue checked by a monitor.
`timescale 1ns/1ps
module tb_pcid_tlb;

  localparam int NSET = 8;
  localparam int NWAY = 8;
  localparam int LOGW = 3;

  logic        clk = 1'b0;
  logic        shutdown_n, lookup_valid, lookup_ready, resp_valid, resp_hit;
  logic [63:0] lookup_va, resp_pa, fill_va, fill_pa, inv_va, stat_hit, stat_miss;
  logic [11:0] lookup_pcid, fill_pcid, inv_pcid;
  logic        fill_valid, inv_valid, inv_busy;
  logic [1:0]  inv_mode;

  pcid_tlb dut (
    .clk(clk), .shutdown_n(shutdown_n),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
    .lookup_va(lookup_va), .lookup_pcid(lookup_pcid),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_pa(resp_pa),
    .fill_valid(fill_valid), .fill_va(fill_va), .fill_pcid(fill_pcid), .fill_pa(fill_pa),
    .inv_valid(inv_valid), .inv_mode(inv_mode), .inv_va(inv_va), .inv_pcid(inv_pcid),
    .inv_busy(inv_busy), .stat_hit(stat_hit), .stat_miss(stat_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [63:0] pa;
    logic [63:0] nhit;
    logic [63:0] nmiss;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: one entry per (set, way) keyed by full VPN, plus a PLRU tree.
  bit          mv    [NSET][NWAY];
  logic [63:0] mvpn  [NSET][NWAY];
  logic [11:0] mpcid [NSET][NWAY];
  logic [63:0] mppn  [NSET][NWAY];
  bit          tree  [NSET][NWAY];
  logic [63:0] mhits, mmiss;
  int          busy_cnt;

  // Pending stimulus for the next cycle.
  bit          s_rst_n, s_lv, s_fv, s_iv;
  logic [63:0] s_lva, s_fva, s_fpa, s_iva;
  logic [11:0] s_lpcid, s_fpcid, s_ipcid;
  logic [1:0]  s_imode;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    for (int s = 0; s < NSET; s++)
      for (int w = 0; w < NWAY; w++) begin
        mv[s][w]   = 1'b0;
        tree[s][w] = 1'b0;
      end
    mhits    = 0;
    mmiss    = 0;
    busy_cnt = 0;
  endfunction

  function automatic int mFind(input logic [63:0] vpn, input logic [11:0] pcid);
    int s = int'(vpn % NSET);
    for (int w = 0; w < NWAY; w++)
      if (mv[s][w] && mvpn[s][w] == vpn && mpcid[s][w] == pcid) return w;
    return -1;
  endfunction

  function automatic void mTouch(input int s, input int w);
    for (int k = 1; k <= LOGW; k++) begin
      int node  = (w + NWAY) >> k;
      int child = (w + NWAY) >> (k - 1);
      tree[s][node] = (child % 2 == 0);
    end
  endfunction

  function automatic int mVictim(input int s);
    int node = 1;
    while (node < NWAY) node = 2 * node + int'(tree[s][node]);
    return node - NWAY;
  endfunction

  function automatic void mFill(input logic [63:0] va, input logic [11:0] pcid, input logic [63:0] pa);
    logic [63:0] vpn = va >> 12;
    int s = int'(vpn % NSET);
    int w = mFind(vpn, pcid);
    if (w < 0)
      for (int i = NWAY - 1; i >= 0; i--) if (!mv[s][i]) w = i;
    if (w < 0) w = mVictim(s);
    mv[s][w]    = 1'b1;
    mvpn[s][w]  = vpn;
    mpcid[s][w] = pcid;
    mppn[s][w]  = pa >> 12;
    mTouch(s, w);
  endfunction

  function automatic void mInv(input logic [1:0] mode, input logic [63:0] va, input logic [11:0] pcid);
    int w;
    case (mode)
      2'd0: begin
        w = mFind(va >> 12, pcid);
        if (w >= 0) mv[int'((va >> 12) % NSET)][w] = 1'b0;
      end
      2'd1: begin
        for (int s = 0; s < NSET; s++)
          for (int i = 0; i < NWAY; i++) if (mpcid[s][i] == pcid) mv[s][i] = 1'b0;
        busy_cnt = NSET;
      end
      2'd2: modelReset_keepStats();
      default: ;
    endcase
  endfunction

  function automatic void modelReset_keepStats();
    for (int s = 0; s < NSET; s++)
      for (int i = 0; i < NWAY; i++) begin
        mv[s][i]   = 1'b0;
        tree[s][i] = 1'b0;
      end
  endfunction

  function automatic void clearStim();
    s_rst_n = 1'b1; s_lv = 1'b0; s_fv = 1'b0; s_iv = 1'b0;
    s_lva = '0; s_fva = '0; s_fpa = '0; s_iva = '0;
    s_lpcid = '0; s_fpcid = '0; s_ipcid = '0; s_imode = '0;
  endfunction

  // Drives one cycle at the falling edge, updates the model and advances a clock.
  task automatic applyStimulus();
    exp_t e;
    int   w;
    bit   busy;
    shutdown_n = s_rst_n; lookup_valid = s_lv; lookup_va = s_lva; lookup_pcid = s_lpcid;
    fill_valid = s_fv; fill_va = s_fva; fill_pcid = s_fpcid; fill_pa = s_fpa;
    inv_valid = s_iv; inv_mode = s_imode; inv_va = s_iva; inv_pcid = s_ipcid;
    busy = (busy_cnt > 0);
    if (!s_rst_n) begin
      modelReset();
    end else begin
      checkOutput("lookup_ready", 64'(lookup_ready), 64'(!busy));
      checkOutput("inv_busy", 64'(inv_busy), 64'(busy));
      if (s_lv && !busy) begin
        w = mFind(s_lva >> 12, s_lpcid);
        if (w >= 0) begin
          mhits++;
          e.hit = 1'b1;
          e.pa  = (mppn[int'((s_lva >> 12) % NSET)][w] << 12) | (s_lva & 64'hfff);
          mTouch(int'((s_lva >> 12) % NSET), w);
        end else begin
          mmiss++;
          e.hit = 1'b0;
          e.pa  = '0;
        end
        e.nhit  = mhits;
        e.nmiss = mmiss;
        sb.push_back(e);
      end
      if (s_fv && !busy && !s_iv) mFill(s_fva, s_fpcid, s_fpa);
      if (busy) busy_cnt--;
      else if (s_iv) mInv(s_imode, s_iva, s_ipcid);
    end
    clearStim();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doLookup(input logic [63:0] va, input logic [11:0] pcid);
    s_lv = 1'b1; s_lva = va; s_lpcid = pcid;
    applyStimulus();
  endtask

  task automatic doFill(input logic [63:0] va, input logic [11:0] pcid, input logic [63:0] pa);
    s_fv = 1'b1; s_fva = va; s_fpcid = pcid; s_fpa = pa;
    applyStimulus();
  endtask

  task automatic doInv(input logic [1:0] mode, input logic [63:0] va, input logic [11:0] pcid);
    s_iv = 1'b1; s_imode = mode; s_iva = va; s_ipcid = pcid;
    applyStimulus();
  endtask

  task automatic doReset();
    s_rst_n = 1'b0;
    applyStimulus();
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_stat_hit", stat_hit, 64'd0);
    checkOutput("rst_stat_miss", stat_miss, 64'd0);
    checkOutput("rst_inv_busy", 64'(inv_busy), 64'd0);
  endtask

  function automatic logic [63:0] setVa(input int tag, input int set);
    return (64'(tag) << 15) | (64'(set) << 12);
  endfunction

  // Monitor: every presented response is compared with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_resp", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("resp_hit", 64'(resp_hit), 64'(e.hit));
        checkOutput("resp_pa", resp_pa, e.pa);
        checkOutput("stat_hit", stat_hit, e.nhit);
        checkOutput("stat_miss", stat_miss, e.nmiss);
      end
    end
  end

  initial begin
    clearStim();
    modelReset();
    @(negedge clk);
    doReset();
    doReset();

    // First lookup after reset misses.
    doLookup(64'h0000_0000_0040_1123, 12'd5);
    // Fill, then hit with matching PCID and miss with another PCID.
    doFill(64'h401000, 12'd5, 64'h8_2000);
    doLookup(64'h401abc, 12'd5);
    doLookup(64'h401abc, 12'd6);

    // Nine tags into set 1: the ninth evicts way 0; refill updates in place.
    doReset();
    for (int t = 0; t < 9; t++) doFill(setVa(t, 1), 12'd7, 64'(t + 100) << 12);
    for (int t = 0; t < 9; t++) doLookup(setVa(t, 1) | 64'h55, 12'd7);
    doFill(setVa(3, 1), 12'd7, 64'hdead_b000);
    for (int t = 0; t < 9; t++) doLookup(setVa(t, 1) | 64'h1, 12'd7);

    // PCID sweep: lookups held during the sweep, pcid 3 gone, pcid 4 intact.
    doReset();
    for (int s = 0; s < NSET; s++) begin
      doFill(setVa(1, s), 12'd3, 64'(s + 200) << 12);
      doFill(setVa(2, s), 12'd4, 64'(s + 300) << 12);
    end
    doInv(2'd1, '0, 12'd3);
    for (int i = 0; i < NSET; i++) doLookup(setVa(2, i), 12'd4);
    for (int s = 0; s < NSET; s++) begin
      doLookup(setVa(1, s), 12'd3);
      doLookup(setVa(2, s), 12'd4);
    end

    // Page invalidation then global flush.
    doFill(setVa(5, 2), 12'd9, 64'h7000);
    doFill(setVa(5, 3), 12'd9, 64'h9000);
    doInv(2'd0, setVa(5, 2), 12'd9);
    doLookup(setVa(5, 2), 12'd9);
    doLookup(setVa(5, 3), 12'd9);
    doInv(2'd2, '0, '0);
    doLookup(setVa(5, 3), 12'd9);
    doLookup(setVa(2, 0), 12'd4);

    // Reset during the third sweep cycle aborts the sweep.
    for (int s = 0; s < NSET; s++) doFill(setVa(1, s), 12'd3, 64'h1000);
    doLookup(setVa(1, 0), 12'd3);
    doInv(2'd1, '0, 12'd3);
    applyStimulus();
    applyStimulus();
    doReset();
    for (int s = 0; s < NSET; s++) doLookup(setVa(1, s), 12'd3);

    // Random traffic on a small address space so hits, evictions and PLRU matter.
    for (int i = 0; i < 2000; i++) begin
      s_lv    = ($urandom_range(0, 99) < 60);
      s_lva   = setVa($urandom_range(0, 11), $urandom_range(0, 7)) | 64'($urandom_range(0, 4095));
      s_lpcid = 12'($urandom_range(1, 3));
      s_fv    = ($urandom_range(0, 99) < 35);
      s_fva   = setVa($urandom_range(0, 11), $urandom_range(0, 7));
      s_fpcid = 12'($urandom_range(1, 3));
      s_fpa   = {$urandom, $urandom};
      s_iv    = ($urandom_range(0, 99) < 4);
      s_imode = 2'($urandom_range(0, 3));
      s_iva   = setVa($urandom_range(0, 11), $urandom_range(0, 7));
      s_ipcid = 12'($urandom_range(1, 3));
      applyStimulus();
    end

    applyStimulus();
    applyStimulus();
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcid_tlb.md
Name: pcid_tlb

Overview:
- Parametrised set-associative, PCID-tagged TLB; next generation of the single-level TLB feeding the MMU.
- Adds three invalidation modes (page, per-PCID sweep, global flush) sequenced by an FSM.
- Adds a valid/ready lookup handshake with a registered response, fill-in-place update, tree-PLRU replacement and saturating hit/miss statistics.

Parameters:
SADDR, 64, virtual/physical address width in bits
SPAGE, 12, page offset width in bits (page size 2^SPAGE)
NSET, 8, number of sets; power of two, >=2
NWAY, 8, ways per set; power of two, >=2
SPCID, 12, PCID width in bits

Ports:
clk  in  1  clock; all state updates on the rising edge
shutdown_n  in  1  reset, synchronous, active-low
lookup_valid  in  1  translation request
lookup_ready  out  1  request accepted when valid&ready
lookup_va  in  SADDR  virtual address
lookup_pcid  in  SPCID  process context id
resp_valid  out  1  response strobe, one cycle
resp_hit  out  1  1 = translation found
resp_pa  out  SADDR  {PPN, va[SPAGE-1:0]}; 0 on miss
fill_valid  in  1  install a translation
fill_va  in  SADDR  VA of the fill
fill_pcid  in  SPCID  PCID of the fill
fill_pa  in  SADDR  PA of the fill; low SPAGE bits ignored
inv_valid  in  1  invalidation request
inv_mode  in  2  0 page, 1 by-PCID, 2 global, 3 reserved
inv_va  in  SADDR  VA for mode 0
inv_pcid  in  SPCID  PCID for modes 0/1
inv_busy  out  1  invalidation in progress
stat_hit  out  64  saturating hit counter
stat_miss  out  64  saturating miss counter

Behaviour:
- Reset (shutdown_n=0 at an edge): all valid bits 0; PLRU bits 0; FSM to IDLE; resp_valid, resp_hit, resp_pa, inv_busy, stat_hit, stat_miss all 0. Reset mid-sweep aborts the sweep.
- Address split: set = va[SPAGE +: log2(NSET)]; tag = va[SADDR-1 : SPAGE+log2(NSET)]; entry = {valid, pcid, tag, ppn}.
- Hit condition: valid && tag match && pcid match. Multiple matching ways cannot occur (fill updates in place).
- lookup_ready = (state==IDLE).
- Lookup latency: accepted at edge N; resp_valid=1 for exactly the cycle after edge N, with resp_hit and resp_pa.
- resp_pa on miss is 0. Back-to-back lookups are allowed every cycle.
- Hit updates the set's tree-PLRU to point away from the hit way.
- stat_hit/stat_miss increment on each response; they hold at 2^64-1.
- Fill, honoured only in IDLE and when inv_valid=0, is written at the edge.
- Fill way selection, in priority order:
  - the existing matching way (tag+pcid), updated in place;
  - otherwise the lowest-index invalid way;
  - otherwise the PLRU victim.
- A fill updates PLRU as a touch of the written way. Fills while inv_busy=1 or coincident with inv_valid are dropped.
- Lookup and fill in the same cycle: the lookup sees pre-fill contents (no bypass). A fill-then-lookup on the next cycle hits.
- FSM states and transitions:
  - IDLE: inv_valid accepted.
  - Mode 0: clears the matching way in the one set, at the same edge; stays IDLE; inv_busy stays 0.
  - Mode 2: clears every valid bit and resets PLRU, at the same edge; stays IDLE.
  - Mode 1: go to SWEEP with index=0.
  - Mode 3: no-op.
  - SWEEP: inv_busy=1 and lookup_ready=0. Each cycle, clear all ways in set[index] whose pcid==inv_pcid (latched at accept); index++. After set NSET-1 is processed, return to IDLE. inv_busy is therefore high for exactly NSET cycles.
  - inv_valid during SWEEP is ignored.
- Lookup coincident with an accepted inv_valid in IDLE: the lookup is evaluated against pre-invalidation contents.

Test Plan:
- Reset, then lookup va=64'h0000_0000_0040_1123, pcid=5 -> resp_valid next cycle; resp_hit=0, resp_pa=0; stat_miss=1.
- Fill va=64'h401000, pcid=5, pa=64'h8_2000; then lookup va=64'h401abc, pcid=5 -> hit, resp_pa=64'h8_2abc. Same VA with pcid=6 -> miss.
- Fill 9 distinct tags into set 1 (NWAY=8), touching ways 0..7 in order before the 9th -> 9th replaces way 0. Re-filling an existing tag with a new pa updates in place, and no eviction occurs.
- Fill pcid=3 entries into every set; issue inv_mode=1, inv_pcid=3 -> inv_busy high 8 cycles, lookup_ready=0; afterwards all pcid=3 lookups miss and pcid=4 entries still hit.
- inv_mode=0 on a filled page -> next-cycle lookup misses, neighbouring page hits. inv_mode=2 -> all lookups miss.
- Assert shutdown_n=0 during the 3rd SWEEP cycle -> inv_busy=0 and counters=0 after the edge; all lookups miss.
